cmd_input_queue: RTL and testbench
==================================

Name: cmd_input_queue

Overview:
- Parametrised command-ingest block for the tetris datapath.
- Merges NSRC independent command sources (buttons, switches, UART decoder, gravity/bar timers) into one DEPTH-entry FIFO of state_type commands.
- Adds per-source auto-repeat (DAS/ARR), coalescing of redundant commands, overflow accounting and flush.
- Sits between the input decoders and the game-state FSM; the FSM pops one command each time it is in WAIT.

Parameters:
- NSRC, 4, number of command sources; index 0 has the highest priority.
- DEPTH, 8, FIFO entries; must be at least 2.
- DAS_TICK, 20_000_000, hold cycles before the first auto-repeat.
- ARR_TICK, 5_000_000, cycles between subsequent repeats.
- REPEAT_EN, all ones, NSRC-bit mask of sources allowed to auto-repeat.
- COALESCE_MASK, bit DOWN set, one bit per state_type value; marks commands that merge with an identical tail entry.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of queue and repeat state.
- src_valid  in  NSRC  one-cycle request per source.
- src_cmd  in  NSRC*CMD_W  packed state_type per source.
- src_hold  in  NSRC  level: source key is still held.
- pop  in  1  consumer takes the head entry.
- cmd  out  CMD_W  head entry; NONE when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a push was dropped because the queue was full.
- drop_cnt  out  8  saturating count of overflow drops.

Behaviour:
- Reset: queue all NONE, count 0, empty 1, full 0, overflow 0, drop_cnt 0, all repeat timers idle.
- Request formation: a source's effective request is src_valid OR its repeat pulse. A request carrying cmd NONE is ignored.
- Arbitration: at most one push per cycle. The lowest-index requesting source wins. Losing requests are discarded without being counted.
- Coalesce: if the winning cmd has its COALESCE_MASK bit set, count > 0, and the tail entry equals the cmd, the push is silently absorbed. Nothing changes and nothing is counted.
- Push to a non-full queue: the entry is written at the tail. It becomes visible on cmd the next cycle if the queue was empty (1-cycle latency).
- Push while full and no pop: the entry is dropped, overflow is set to 1, and drop_cnt increments, saturating at 255.
- Pop: honoured only when count > 0 at cycle start. The head shifts out and cmd shows the next entry, or NONE, the following cycle.
- Simultaneous push and pop:
  - When full: both take effect; count is unchanged; no overflow.
  - When empty: only the push takes effect.
- Auto-repeat, per source with its REPEAT_EN bit set:
  - Idle → DAS on src_valid with src_hold high.
  - DAS → after DAS_TICK consecutive hold cycles, emit a repeat pulse with the latched cmd and go to ARR.
  - ARR → emit a pulse every ARR_TICK cycles.
  - src_hold low in any state → Idle within 1 cycle.
  - A new src_valid in DAS or ARR relatches cmd and restarts DAS.
  - Repeat pulses obey arbitration, coalescing and overflow exactly like src_valid.
- flush: clears the queue, count and sticky overflow. drop_cnt is kept. All repeaters go Idle. Pushes and pops in the same cycle are discarded. Flush has priority over everything except reset.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- Counters are sized $clog2(DAS_TICK)+1 bits; no wrap is possible.

Decomposition:
- Package enum_type:
  - state_type (existing).
  - CMD_W = $bits(state_type).
  - default DAS_TICK and ARR_TICK derived from SEC_TICK.
  - a function is_coalescible(state_type, mask).
- Sub-module key_repeater: one instance per source via generate, gated by REPEAT_EN. Ports: clk, reset_n, flush, valid, hold, cmd_in, rep_pulse, rep_cmd.
- FIFO storage, arbiter and counters are in the top module.

Test Plan (NSRC=3, DEPTH=4, DAS_TICK=6, ARR_TICK=2, COALESCE_MASK=DOWN):
- Sources 0 and 2 pulse LEFT and RIGHT in the same cycle, then pop in WAIT → cmd=LEFT next cycle, count=1, RIGHT never appears.
- 5 single-cycle pushes (LEFT, RIGHT, ROTATE, DROP, HOLD) with no pop → count=4, full=1, overflow=1, drop_cnt=1, head LEFT; 4 pops yield LEFT, RIGHT, ROTATE, DROP, then cmd=NONE and empty=1.
- Full queue, push HOLD and pop in the same cycle → count stays 4, overflow stays 0, tail=HOLD.
- Source 1 pulses DOWN three times with no pop → count=1, single DOWN entry; then ROTATE followed by DOWN → count=3.
- Source 0 pulses RIGHT with src_hold held 12 cycles → RIGHT entries from the initial press, 6 cycles later, then every 2 cycles (4 total); releasing hold stops repeats within 1 cycle.
- flush with count=3 and a concurrent push → next cycle count=0, cmd=NONE, overflow=0, drop_cnt unchanged; asynchronous reset_n low mid-repeat → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/cmd_input_queue_pkg.sv
// Shared command type and helpers for the tetris command-ingest path.
//   state_type       : command / game-state encoding carried through the queue
//   CMD_W            : width of a packed state_type
//   SEC_TICK         : clock cycles per second; DAS/ARR defaults derive from it
//   COALESCE_DEF     : default coalesce mask (DOWN only)
//   is_coalescible() : tests a command against a per-command coalesce mask
package enum_type;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    DOWN   = 3'd3,
    ROTATE = 3'd4,
    DROP   = 3'd5,
    HOLD   = 3'd6
  } state_type;

  localparam int CMD_W    = $bits(state_type);
  localparam int NUM_CMDS = 2 ** CMD_W;

  localparam int unsigned SEC_TICK     = 100_000_000;
  localparam int unsigned DAS_TICK_DEF = SEC_TICK / 5;   // 200 ms
  localparam int unsigned ARR_TICK_DEF = SEC_TICK / 20;  // 50 ms

  localparam logic [NUM_CMDS-1:0] COALESCE_DEF = NUM_CMDS'(1) << DOWN;

  function automatic logic is_coalescible(input state_type c,
                                          input logic [NUM_CMDS-1:0] mask);
    return mask[c];
  endfunction

endpackage

// File: rtl/cmd_input_queue_repeater.sv
// key_repeater: per-source auto-repeat (DAS then ARR) generator.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous return to idle
//   valid, hold  : source request pulse and held-key level
//   cmd_in       : command latched on a held press
//   rep_pulse    : one-cycle repeat request
//   rep_cmd      : latched command accompanying rep_pulse
module key_repeater
  import enum_type::*;
#(
  parameter int unsigned DAS_TICK = DAS_TICK_DEF,
  parameter int unsigned ARR_TICK = ARR_TICK_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush,
  input  logic      valid,
  input  logic      hold,
  input  state_type cmd_in,
  output logic      rep_pulse,
  output state_type rep_cmd
);

  localparam int unsigned CNT_W = $clog2(DAS_TICK) + 1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DAS,
    R_ARR
  } rep_state_t;

  rep_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  state_type        cmd_q, cmd_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= R_IDLE;
      cnt   <= '0;
      cmd_q <= NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cmd_q <= cmd_nxt;
    end
  end

  // cnt counts cycles spent in the current phase; pulses are gated by hold
  // so a release suppresses any repeat in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd_q;
    rep_pulse = 1'b0;
    case (state)
      R_DAS: begin
        if (hold && cnt == CNT_W'(DAS_TICK - 1)) begin
          rep_pulse = 1'b1;
          state_nxt = R_ARR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      R_ARR: begin
        if (hold && cnt == CNT_W'(ARR_TICK - 1)) begin
          rep_pulse = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (valid && hold) begin
      state_nxt = R_DAS;
      cnt_nxt   = '0;
      cmd_nxt   = cmd_in;
    end else if (!hold) begin
      state_nxt = R_IDLE;
      cnt_nxt   = '0;
    end

    if (flush) begin
      state_nxt = R_IDLE;
      cnt_nxt   = '0;
    end
  end

  assign rep_cmd = cmd_q;

endmodule

// File: rtl/cmd_input_queue.sv
// cmd_input_queue: merges NSRC command sources into a DEPTH-entry FIFO.
//   clk, reset_n  : clock, asynchronous active-low reset
//   flush         : synchronous clear of queue, overflow and repeaters
//   src_valid     : per-source one-cycle request
//   src_cmd       : packed per-source state_type commands
//   src_hold      : per-source held-key level (auto-repeat)
//   pop           : consumer takes head entry
//   cmd           : head entry, NONE when empty
//   count         : occupancy; empty/full flags
//   overflow      : sticky dropped-push flag; drop_cnt saturating drop count
module cmd_input_queue
  import enum_type::*;
#(
  parameter int unsigned          NSRC          = 4,
  parameter int unsigned          DEPTH         = 8,
  parameter int unsigned          DAS_TICK      = DAS_TICK_DEF,
  parameter int unsigned          ARR_TICK      = ARR_TICK_DEF,
  parameter logic [NSRC-1:0]      REPEAT_EN     = '1,
  parameter logic [NUM_CMDS-1:0]  COALESCE_MASK = COALESCE_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NSRC-1:0]              src_valid,
  input  logic [NSRC*CMD_W-1:0]        src_cmd,
  input  logic [NSRC-1:0]              src_hold,
  input  logic                         pop,
  output logic [CMD_W-1:0]             cmd,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic [7:0]                   drop_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_type       q     [DEPTH];
  state_type       q_nxt [DEPTH];
  logic [CW-1:0]   count_nxt;
  logic [NSRC-1:0] rep_pulse;
  state_type       rep_cmd [NSRC];
  state_type       req_cmd [NSRC];
  logic [NSRC-1:0] req;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    state_type in_cmd;
    assign in_cmd = state_type'(src_cmd[i*CMD_W +: CMD_W]);

    if (REPEAT_EN[i]) begin : g_rep
      key_repeater #(
        .DAS_TICK (DAS_TICK),
        .ARR_TICK (ARR_TICK)
      ) u_rep (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .valid     (src_valid[i]),
        .hold      (src_hold[i]),
        .cmd_in    (in_cmd),
        .rep_pulse (rep_pulse[i]),
        .rep_cmd   (rep_cmd[i])
      );
    end else begin : g_norep
      assign rep_pulse[i] = 1'b0;
      assign rep_cmd[i]   = NONE;
    end

    // A fresh press overrides a coincident repeat of the old command.
    assign req_cmd[i] = src_valid[i] ? in_cmd : rep_cmd[i];
    assign req[i]     = (src_valid[i] | rep_pulse[i]) && (req_cmd[i] != NONE);
  end

  logic          have_req, pop_ok, coalesce, push_ok, drop;
  state_type     win_cmd, tail_cmd;
  logic [CW-1:0] base;

  always_comb begin
    have_req = 1'b0;
    win_cmd  = NONE;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (req[i] && !have_req) begin
        have_req = 1'b1;
        win_cmd  = req_cmd[i];
      end
    end

    tail_cmd = NONE;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count) tail_cmd = q[i];
    end

    pop_ok   = pop && (count != '0);
    coalesce = have_req && is_coalescible(win_cmd, COALESCE_MASK) &&
               (count != '0) && (tail_cmd == win_cmd);
    push_ok  = have_req && !coalesce && (!full || pop_ok);
    drop     = have_req && !coalesce && full && !pop_ok;

    // Pop shifts toward the head first, then the push lands just past the
    // surviving entries, so a full push+pop leaves the count unchanged.
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      q_nxt[i] = pop_ok ? q[i + 1] : q[i];
    end
    q_nxt[DEPTH-1] = pop_ok ? NONE : q[DEPTH-1];

    base = count - CW'(pop_ok);
    if (push_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == base) q_nxt[i] = win_cmd;
      end
    end
    count_nxt = base + CW'(push_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= NONE;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= NONE;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      q     <= q_nxt;
      count <= count_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign cmd   = q[0];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_cmd_input_queue.sv
module tb_cmd_input_queue;
  import enum_type::*;

  localparam int NSRC  = 3;
  localparam int DEPTH = 4;
  localparam int DAS   = 6;
  localparam int ARR   = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [NUM_CMDS-1:0] COAL = NUM_CMDS'(1) << DOWN;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush;
  logic [NSRC-1:0]        src_valid;
  logic [NSRC*CMD_W-1:0]  src_cmd;
  logic [NSRC-1:0]        src_hold;
  logic                   pop;
  logic [CMD_W-1:0]       cmd;
  logic [CW-1:0]          count;
  logic                   empty, full, overflow;
  logic [7:0]             drop_cnt;

  state_type cmd_v [NSRC];

  always #5 clk = ~clk;

  always_comb begin
    src_cmd = '0;
    for (int i = 0; i < NSRC; i++) src_cmd[i*CMD_W +: CMD_W] = cmd_v[i];
  end

  cmd_input_queue #(
    .NSRC          (NSRC),
    .DEPTH         (DEPTH),
    .DAS_TICK      (DAS),
    .ARR_TICK      (ARR),
    .REPEAT_EN     (3'b111),
    .COALESCE_MASK (COAL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_cmd   (src_cmd),
    .src_hold  (src_hold),
    .pop       (pop),
    .cmd       (cmd),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // Reference model: a plain queue plus per-source "pressed at cycle p" records.
  state_type mq[$];
  bit        m_ovf;
  int        m_drop;
  bit        r_act   [NSRC];
  int        r_press [NSRC];
  state_type r_cmd   [NSRC];
  int        cyc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 0;
    m_drop = 0;
    for (int i = 0; i < NSRC; i++) begin
      r_act[i] = 0; r_press[i] = 0; r_cmd[i] = NONE;
    end
  endtask

  task automatic model_step();
    bit        have, pulse, absorb, full_b, pop_ok;
    state_type wc, c;
    int        k;
    have = 0;
    wc   = NONE;
    for (int i = 0; i < NSRC; i++) begin
      k     = cyc - r_press[i];
      pulse = r_act[i] && src_hold[i] && (k >= DAS) && (((k - DAS) % ARR) == 0);
      c     = src_valid[i] ? cmd_v[i] : (pulse ? r_cmd[i] : NONE);
      if (!have && (src_valid[i] || pulse) && c != NONE) begin
        have = 1; wc = c;
      end
    end
    if (flush) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      full_b = (mq.size() == DEPTH);
      pop_ok = pop && (mq.size() > 0);
      absorb = have && COAL[wc] && (mq.size() > 0) && (mq[$] == wc);
      if (pop_ok) void'(mq.pop_front());
      if (have && !absorb) begin
        if (!full_b || pop_ok) mq.push_back(wc);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (flush) r_act[i] = 0;
      else if (src_valid[i] && src_hold[i]) begin
        r_act[i] = 1; r_press[i] = cyc; r_cmd[i] = cmd_v[i];
      end else if (!src_hold[i]) r_act[i] = 0;
    end
  endtask

  task automatic check_all();
    state_type e;
    e = (mq.size() > 0) ? mq[0] : NONE;
    check("cmd",      32'(cmd),      32'(e));
    check("count",    32'(count),    32'(mq.size()));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("full",     32'(full),     32'(mq.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic clear_inputs();
    flush = 0; pop = 0; src_valid = '0;
    for (int i = 0; i < NSRC; i++) cmd_v[i] = NONE;
  endtask

  task automatic push1(input int s, input state_type c);
    src_valid[s] = 1'b1; cmd_v[s] = c;
    tick();
    src_valid[s] = 1'b0; cmd_v[s] = NONE;
  endtask

  task automatic pop1();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  state_type seq5 [5];

  initial begin
    reset_n  = 1'b0;
    src_hold = '0;
    cyc      = 0;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    check("reset_cmd",   32'(cmd),   32'(NONE));
    check("reset_empty", 32'(empty), 32'd1);
    check_all();
    reset_n = 1'b1;
    tick();

    // Same-cycle requests from sources 0 and 2: only LEFT is queued.
    src_valid = 3'b101; cmd_v[0] = LEFT; cmd_v[2] = RIGHT;
    tick();
    clear_inputs();
    check("arb_cmd",   32'(cmd),   32'(LEFT));
    check("arb_count", 32'(count), 32'd1);
    pop1();
    check("arb_after_pop", 32'(cmd), 32'(NONE));

    // Five pushes into a 4-deep queue.
    seq5 = '{LEFT, RIGHT, ROTATE, DROP, HOLD};
    foreach (seq5[i]) push1(1, seq5[i]);
    check("ovf_count", 32'(count),    32'd4);
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd1);
    check("ovf_head",  32'(cmd),      32'(LEFT));
    for (int i = 1; i < 5; i++) begin
      pop1();
      check("drain_head", 32'(cmd), 32'((i < 4) ? seq5[i] : NONE));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Push and pop together on a full queue.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 4; i++) push1(1, seq5[i]);
    src_valid[1] = 1'b1; cmd_v[1] = HOLD; pop = 1'b1;
    tick();
    clear_inputs();
    check("pp_count", 32'(count),    32'd4);
    check("pp_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) pop1();
    check("pp_tail", 32'(cmd), 32'(HOLD));
    pop1();

    // DOWN coalescing against an identical tail entry.
    for (int i = 0; i < 3; i++) push1(1, DOWN);
    check("coal_count", 32'(count), 32'd1);
    push1(1, ROTATE);
    push1(1, DOWN);
    check("coal_count2", 32'(count), 32'd3);

    // Flush with a concurrent push.
    flush = 1'b1; src_valid[0] = 1'b1; cmd_v[0] = LEFT;
    tick();
    clear_inputs();
    check("flush_count", 32'(count),    32'd0);
    check("flush_cmd",   32'(cmd),      32'(NONE));
    check("flush_ovf",   32'(overflow), 32'd0);
    check("flush_drops", 32'(drop_cnt), 32'd1);

    // Auto-repeat: held 12 cycles gives press + repeats at +6, +8, +10.
    src_hold[0] = 1'b1;
    push1(0, RIGHT);
    for (int i = 0; i < 11; i++) tick();
    src_hold[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rep_count", 32'(count),    32'd4);
    check("rep_ovf",   32'(overflow), 32'd0);
    check("rep_head",  32'(cmd),      32'(RIGHT));
    flush = 1'b1; tick(); flush = 1'b0;

    // Asynchronous reset in the middle of a repeat burst.
    src_hold[0] = 1'b1;
    push1(0, DOWN);
    for (int i = 0; i < 8; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_cmd",   32'(cmd),      32'(NONE));
    check("areset_count", 32'(count),    32'd0);
    check("areset_empty", 32'(empty),    32'd1);
    check("areset_full",  32'(full),     32'd0);
    check("areset_ovf",   32'(overflow), 32'd0);
    check("areset_drops", 32'(drop_cnt), 32'd0);
    model_reset();
    src_hold = '0;
    reset_n  = 1'b1;
    tick();

    // Randomised traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        src_valid[i] = ($urandom_range(0, 5) == 0);
        cmd_v[i]     = state_type'($urandom_range(0, 6));
        if (src_valid[i]) src_hold[i] = ($urandom_range(0, 3) != 0);
        else if ($urandom_range(0, 9) == 0) src_hold[i] = 1'b0;
      end
      pop   = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 79) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
